// File: rtl/game_pkg.sv
// Shared types and widths for the classic-mode scoring stage.
//   SCORE_W   : width of each per-enemy kill count
//   NUM_ENEMY : number of enemy tank slots
//   TIMER_W   : width of respawn / invulnerability tick counters
package game_pkg;

  localparam int unsigned SCORE_W   = 5;
  localparam int unsigned NUM_ENEMY = 4;
  localparam int unsigned TIMER_W   = 8;

  typedef enum logic {
    ALIVE = 1'b0,
    DEAD  = 1'b1
  } slot_state_t;

  typedef enum logic {
    VULN   = 1'b0,
    INVULN = 1'b1
  } player_state_t;

  // Saturating increment: a score already at the ceiling stays there.
  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] val,
                                                 input logic [SCORE_W-1:0] ceil);
    sat_inc = (val >= ceil) ? ceil : val + SCORE_W'(1);
  endfunction

endpackage

// File: rtl/enemy_slot.sv
// One enemy tank slot: counts kills and holds the enemy dead for a fixed
// number of tick strobes after each accepted hit.
//   clk, rst   : clock, synchronous active-high reset
//   clr        : synchronous clear, same effect as rst
//   tick       : one-cycle time-base strobe
//   hit_evt    : single-cycle hit event (already edge-detected)
//   score      : saturating kill count
//   alive      : 1 while the enemy is on the field
module enemy_slot
  import game_pkg::*;
#(
  parameter int unsigned RESPAWN_TICKS = 30,
  parameter int unsigned SCORE_MAX     = 31
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               tick,
  input  logic               hit_evt,
  output logic [SCORE_W-1:0] score,
  output logic               alive
);

  localparam logic [TIMER_W-1:0] RESPAWN_LD = TIMER_W'(RESPAWN_TICKS);
  localparam logic [SCORE_W-1:0] SCORE_SAT  = SCORE_W'(SCORE_MAX);

  slot_state_t        state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic               alive_q, alive_d;

  // Next-state: kill on an event while alive, count ticks down while dead.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    score_d = score_q;
    alive_d = alive_q;
    unique case (state_q)
      ALIVE: begin
        if (hit_evt) begin
          state_d = DEAD;
          timer_d = RESPAWN_LD;
          score_d = sat_inc(score_q, SCORE_SAT);
          alive_d = 1'b0;
        end
      end
      DEAD: begin
        // Hits are ignored here, including one coincident with the last tick.
        if (tick) begin
          if (timer_q <= TIMER_W'(1)) begin
            state_d = ALIVE;
            timer_d = '0;
            alive_d = 1'b1;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      default: begin
        state_d = ALIVE;
        alive_d = 1'b1;
      end
    endcase
  end

  // State register with synchronous reset / clear.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= ALIVE;
      timer_q <= '0;
      score_q <= '0;
      alive_q <= 1'b1;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      score_q <= score_d;
      alive_q <= alive_d;
    end
  end

  assign score = score_q;
  assign alive = alive_q;

endmodule

// File: rtl/enemy_score_tracker.sv
// Classic-mode scoring stage: turns raw collision levels for four enemies and
// the player into per-enemy kill counts, enemy alive flags and a player
// alive/vulnerable flag whose falling edges mark accepted player hits.
//   clk, rst            : clock, synchronous active-high reset
//   enable_game_classic : low clears the block every cycle
//   tick                : one-cycle time-base strobe for all timers
//   enemy_hit[3:0]      : level collision flags, bit i = enemy i
//   mytank_hit          : level collision flag for the player
//   scorea..scored      : kill counts of enemies 0..3
//   enemy_alive[3:0]    : per-enemy alive flags
//   mytank_state        : 1 = vulnerable, 0 = invulnerable after a hit
module enemy_score_tracker
  import game_pkg::*;
#(
  parameter int unsigned RESPAWN_TICKS = 30,
  parameter int unsigned INVULN_TICKS  = 20,
  parameter int unsigned SCORE_MAX     = 31
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable_game_classic,
  input  logic                 tick,
  input  logic [NUM_ENEMY-1:0] enemy_hit,
  input  logic                 mytank_hit,
  output logic [SCORE_W-1:0]   scorea,
  output logic [SCORE_W-1:0]   scoreb,
  output logic [SCORE_W-1:0]   scorec,
  output logic [SCORE_W-1:0]   scored,
  output logic [NUM_ENEMY-1:0] enemy_alive,
  output logic                 mytank_state
);

  localparam logic [TIMER_W-1:0] INVULN_LD = TIMER_W'(INVULN_TICKS);

  logic                 clr;
  logic [NUM_ENEMY-1:0] prev_hit_q, prev_hit_d;
  logic                 prev_my_q, prev_my_d;
  logic [NUM_ENEMY-1:0] hit_evt_c;
  logic                 my_evt_c;

  player_state_t        player_q, player_d;
  logic [TIMER_W-1:0]   inv_timer_q, inv_timer_d;
  logic                 mytank_q, mytank_d;

  logic [SCORE_W-1:0]   slot_score [NUM_ENEMY];
  logic [NUM_ENEMY-1:0] slot_alive;

  assign clr = ~enable_game_classic;

  // Rising-edge detect so a held collision level counts once.
  assign hit_evt_c  = enemy_hit & ~prev_hit_q;
  assign my_evt_c   = mytank_hit & ~prev_my_q;
  assign prev_hit_d = enemy_hit;
  assign prev_my_d  = mytank_hit;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      prev_hit_q <= '0;
      prev_my_q  <= 1'b0;
    end else begin
      prev_hit_q <= prev_hit_d;
      prev_my_q  <= prev_my_d;
    end
  end

  // Independent enemy slots.
  for (genvar i = 0; i < int'(NUM_ENEMY); i++) begin : g_slot
    enemy_slot #(
      .RESPAWN_TICKS(RESPAWN_TICKS),
      .SCORE_MAX    (SCORE_MAX)
    ) u_slot (
      .clk    (clk),
      .rst    (rst),
      .clr    (clr),
      .tick   (tick),
      .hit_evt(hit_evt_c[i]),
      .score  (slot_score[i]),
      .alive  (slot_alive[i])
    );
  end

  // Player FSM next-state: same timer pattern as a slot, without a score.
  always_comb begin
    player_d    = player_q;
    inv_timer_d = inv_timer_q;
    mytank_d    = mytank_q;
    unique case (player_q)
      VULN: begin
        if (my_evt_c) begin
          player_d    = INVULN;
          inv_timer_d = INVULN_LD;
          mytank_d    = 1'b0;
        end
      end
      INVULN: begin
        if (tick) begin
          if (inv_timer_q <= TIMER_W'(1)) begin
            player_d    = VULN;
            inv_timer_d = '0;
            mytank_d    = 1'b1;
          end else begin
            inv_timer_d = inv_timer_q - TIMER_W'(1);
          end
        end
      end
      default: begin
        player_d = VULN;
        mytank_d = 1'b1;
      end
    endcase
  end

  // Player state register.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      player_q    <= VULN;
      inv_timer_q <= '0;
      mytank_q    <= 1'b1;
    end else begin
      player_q    <= player_d;
      inv_timer_q <= inv_timer_d;
      mytank_q    <= mytank_d;
    end
  end

  assign scorea       = slot_score[0];
  assign scoreb       = slot_score[1];
  assign scorec       = slot_score[2];
  assign scored       = slot_score[3];
  assign enemy_alive  = slot_alive;
  assign mytank_state = mytank_q;

endmodule
